// File: rtl/seq_scan_ctrl_if.sv
// Detector-side handshake of the scan controller: clear pulse, serial bit
// with valid/ready flow control, and the detector's match pulse.
interface seq_scan_ctrl_if;
  logic det_clr;
  logic det_valid;
  logic det_bit;
  logic det_ready;
  logic det_hit;

  modport master (
    output det_clr,
    output det_valid,
    output det_bit,
    input  det_ready,
    input  det_hit
  );

  modport slave (
    input  det_clr,
    input  det_valid,
    input  det_bit,
    output det_ready,
    output det_hit
  );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serial scan controller: on a synchronized button edge it clears the
// downstream detector, captures the switch word and streams it out one bit
// per accepted transfer, counting detector hits and completed frames.
module seq_scan_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [WIDTH-1:0] switch,
  seq_scan_ctrl_if.master  det,
  output logic             busy,
  output logic             done,
  output logic [3:0]       hit_cnt,
  output logic             found,
  output logic             drop,
  output logic [7:0]       frame_cnt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [IW-1:0]    idx;
  logic             sync1, sync2, sync3;
  logic [1:0]       warm;
  logic             armed;
  logic             start;
  logic             xfer;

  // Edge is only honoured once the synchronized button has been seen low
  // after reset, so a key held through reset release never starts a frame.
  assign start = armed & sync2 & ~sync3;
  assign xfer  = det.det_valid & det.det_ready;

  // Button synchronizer, edge-detect stage and post-reset arming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
      warm  <= '0;
      armed <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      sync3 <= sync2;
      warm  <= {warm[0], 1'b1};
      if (warm[1] && !sync2) armed <= 1'b1;
    end
  end

  // Frame sequencer with registered outputs, hit counting and drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      sr            <= '0;
      idx           <= '0;
      det.det_clr   <= 1'b0;
      det.det_valid <= 1'b0;
      det.det_bit   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      hit_cnt       <= '0;
      found         <= 1'b0;
      drop          <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      det.det_clr <= 1'b0;
      done        <= 1'b0;

      if (start && state != IDLE) drop <= 1'b1;

      if (det.det_hit && (state == SHIFT || state == DRAIN) && hit_cnt != 4'hF) begin
        hit_cnt <= hit_cnt + 4'd1;
        found   <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= CLR;
            det.det_clr <= 1'b1;
            busy        <= 1'b1;
          end
        end
        CLR: begin
          sr            <= switch;
          idx           <= '0;
          hit_cnt       <= '0;
          found         <= 1'b0;
          drop          <= 1'b0;
          det.det_bit   <= MSB_FIRST ? switch[WIDTH-1] : switch[0];
          det.det_valid <= 1'b1;
          state         <= SHIFT;
        end
        SHIFT: begin
          if (xfer) begin
            idx <= idx + IW'(1);
            // det_bit is pre-loaded with the next bit so it is a plain flop
            if (MSB_FIRST) begin
              sr          <= {sr[WIDTH-2:0], 1'b0};
              det.det_bit <= sr[WIDTH-2];
            end else begin
              sr          <= {1'b0, sr[WIDTH-1:1]};
              det.det_bit <= sr[1];
            end
            if (idx == IW'(WIDTH-1)) begin
              det.det_valid <= 1'b0;
              state         <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          frame_cnt <= frame_cnt + 8'd1;
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          det.det_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: randomized and directed stimulus checked every
// cycle against a queue-based frame model, plus literal expectations.
module tb_seq_scan_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, button;
  logic [W-1:0] sw, sw1;
  logic         busy, done, found, drop;
  logic [3:0]   hit_cnt;
  logic [7:0]   frame_cnt;
  logic         busy1, done1, found1, drop1;
  logic [3:0]   hit_cnt1;
  logic [7:0]   frame_cnt1;

  seq_scan_ctrl_if det ();
  seq_scan_ctrl_if det1 ();

  seq_scan_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .button(button), .switch(sw), .det(det),
    .busy(busy), .done(done), .hit_cnt(hit_cnt), .found(found),
    .drop(drop), .frame_cnt(frame_cnt)
  );

  seq_scan_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .button(button), .switch(sw1), .det(det1),
    .busy(busy1), .done(done1), .hit_cnt(hit_cnt1), .found(found1),
    .drop(drop1), .frame_cnt(frame_cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Start = button sampled low then high on consecutive edges after reset,
  // acted on one cycle later. A frame is: one clear cycle, the captured
  // bits offered in order until each is accepted, one drain, one done.
  bit   mh[3];
  int   mcnt;
  bit   m_active, m_clr, m_valid, m_drain, m_done, m_drop;
  bit   m_q[$];
  int   m_hits, m_frames;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mh = '{0, 0, 0}; mcnt = 0;
      m_active = 0; m_clr = 0; m_valid = 0; m_drain = 0; m_done = 0;
      m_drop = 0; m_hits = 0; m_frames = 0; m_q.delete();
    end else begin : upd
      bit st;
      st = (mcnt >= 3) && mh[1] && !mh[2];
      if (det.det_hit && (m_valid || m_drain)) m_hits = (m_hits < 15) ? m_hits + 1 : 15;
      if (st && m_active) m_drop = 1;
      if (m_clr) begin
        m_q.delete();
        for (int i = 0; i < W; i++) m_q.push_back(sw[W-1-i]);
        m_hits = 0; m_drop = 0; m_clr = 0; m_valid = 1;
      end else if (m_valid) begin
        if (det.det_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin m_valid = 0; m_drain = 1; end
        end
      end else if (m_drain) begin
        m_drain = 0; m_done = 1;
      end else if (m_done) begin
        m_done = 0; m_active = 0; m_frames = (m_frames + 1) % 256;
      end else if (st) begin
        m_active = 1; m_clr = 1;
      end
      mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = button;
      if (mcnt < 3) mcnt++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("det_clr", det.det_clr, m_clr);
      chk("det_valid", det.det_valid, m_valid);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("hit_cnt", hit_cnt, m_hits);
      chk("found", found, m_hits != 0);
      chk("drop", drop, m_drop);
      chk("frame_cnt", frame_cnt, m_frames);
      if (m_valid && m_q.size() > 0) chk("det_bit", det.det_bit, m_q[0]);
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0, clr_cyc = 0, done_cyc = 0, clrs = 0, dones = 0;
  bit xq[$];
  bit xq1[$];

  always @(posedge clk) begin
    cyc++;
    if (rst && det.det_valid && det.det_ready) xq.push_back(det.det_bit);
    if (rst && det1.det_valid && det1.det_ready) xq1.push_back(det1.det_bit);
  end

  always @(negedge clk) begin
    if (det.det_clr) begin clrs++; clr_cyc = cyc; end
    if (done) begin dones++; done_cyc = cyc; end
  end

  // ---------------- detector stub ----------------
  int hit_mode = 0;
  int xfer_n = 0;
  logic [7:0] plan_mask = '0;
  bit inject = 0;

  initial begin : detector
    bit fire;
    det.det_hit = 1'b0;
    forever begin
      @(posedge clk);
      fire = 0;
      if (det.det_valid && det.det_ready) begin
        if (hit_mode == 1 && xfer_n < 8 && plan_mask[xfer_n]) fire = 1;
        if (hit_mode == 2 && $urandom % 3 == 0) fire = 1;
        xfer_n++;
      end
      if (hit_mode == 2 && !det.det_valid && $urandom % 4 == 0) fire = 1;
      if (hit_mode == 3) fire = 1;
      if (inject) fire = 1;
      #1 det.det_hit = fire;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press;
    button = 1'b1; tick; tick;
    button = 1'b0; tick;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    int d0 = dones;
    while (dones == d0 && n < 400) begin tick; n++; end
    chk({name, " done seen"}, dones > d0, 1);
    tick;
  endtask

  function automatic logic [7:0] msb_word(input bit q[$]);
    logic [7:0] w = '0;
    foreach (q[i]) w = {w[6:0], q[i]};
    return w;
  endfunction

  task automatic reset_literals(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " det_valid"}, det.det_valid, 0);
    chk({tag, " det_clr"}, det.det_clr, 0);
    chk({tag, " det_bit"}, det.det_bit, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " hit_cnt"}, hit_cnt, 0);
    chk({tag, " found"}, found, 0);
    chk({tag, " drop"}, drop, 0);
    chk({tag, " frame_cnt"}, frame_cnt, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int n, d0;
    logic [7:0] w1;
    rst = 1'b0; button = 1'b1; sw = '0; sw1 = 8'h01;
    det.det_ready = 1'b0; det1.det_ready = 1'b1; det1.det_hit = 1'b0;
    #12;
    reset_literals("reset");

    // Button held through reset release must not start a frame.
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) tick;
    chk("held button no start", clrs, 0);
    button = 1'b0;
    repeat (3) tick;

    // Directed frame B4, ready always high; LSB-first twin sends 01.
    sw = 8'hB4; det.det_ready = 1'b1;
    xq.delete(); xq1.delete();
    press;
    wait_done("t1");
    chk("t1 bit count", xq.size(), 8);
    chk("t1 bits", msb_word(xq), 8'hB4);
    chk("t1 clr to done", done_cyc - clr_cyc, W + 2);
    chk("t1 frame_cnt", frame_cnt, 1);
    chk("lsb bit count", xq1.size(), 8);
    if (xq1.size() > 0) chk("lsb first bit", xq1[0], 1);
    w1 = '0;
    foreach (xq1[i]) if (i < 8) w1[i] = xq1[i];
    chk("lsb word", w1, 8'h01);

    // A5 with random stalls; switch scrambled after capture.
    sw = 8'hA5; xq.delete();
    button = 1'b1; n = 0; d0 = dones;
    while (dones == d0 && n < 500) begin
      tick; n++;
      if (n == 2) button = 1'b0;
      det.det_ready = ($urandom % 2) == 1;
      if (n >= 6) sw = W'($urandom);
    end
    chk("t2 done seen", dones > d0, 1);
    tick;
    chk("t2 bits", msb_word(xq), 8'hA5);
    chk("t2 bit count", xq.size(), 8);

    // Hits on transfers 0, 3 and the final one; then a stray hit in IDLE.
    det.det_ready = 1'b1; sw = W'($urandom);
    plan_mask = 8'b1000_1001; xfer_n = 0; hit_mode = 1;
    press;
    wait_done("t3");
    hit_mode = 0;
    chk("t3 hit_cnt", hit_cnt, 3);
    chk("t3 found", found, 1);
    inject = 1; tick; inject = 0;
    repeat (3) tick;
    chk("t3 idle hit ignored", hit_cnt, 3);

    // Constant hits with slow acceptance: counter must saturate.
    hit_mode = 3; button = 1'b1; n = 0; d0 = dones;
    while (dones == d0 && n < 500) begin
      tick; n++;
      if (n == 2) button = 1'b0;
      det.det_ready = (n % 3) == 0;
    end
    tick;
    hit_mode = 0; det.det_ready = 1'b1;
    chk("t3b saturate", hit_cnt, 15);
    repeat (2) tick;

    // Second press during SHIFT is dropped; next start clears drop.
    sw = W'($urandom); d0 = dones;
    press;
    tick; tick;
    press;
    wait_done("t4");
    chk("t4 one done", dones - d0, 1);
    chk("t4 drop set", drop, 1);
    press;
    tick;
    chk("t4 drop cleared", drop, 0);
    wait_done("t4b");

    // Reset asserted while the 4th bit is offered.
    xq.delete();
    press;
    n = 0;
    while (xq.size() < 3 && n < 100) begin tick; n++; end
    chk("t5 reached bit 4", xq.size(), 3);
    #2 rst = 1'b0;
    #1 reset_literals("midreset");
    d0 = dones;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) tick;
    chk("t5 no done", dones - d0, 0);
    press;
    wait_done("t5");
    chk("t5 frame_cnt", frame_cnt, 1);

    // Random traffic: button, ready, hits and switch all random.
    hit_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      det.det_ready = ($urandom % 4) != 0;
      sw = W'($urandom);
      if ($urandom % 8 == 0) button = ~button;
      tick;
    end
    button = 1'b0; hit_mode = 0; det.det_ready = 1'b1;
    repeat (40) tick;

    // 256 back-to-back frames from a fresh reset wrap frame_cnt to 0.
    rst = 1'b0; tick; rst = 1'b1;
    repeat (5) tick;
    for (int i = 0; i < 256; i++) begin
      sw = W'($urandom);
      press;
      wait_done("wrap");
      if (i == 254) chk("wrap 255", frame_cnt, 255);
    end
    chk("wrap 0", frame_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of bits in the captured frame (legal range 2..16).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select transmission order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 button  input  1  SHALL be the raw, asynchronous start request from the board key.
REQ-006 switch  input  WIDTH  SHALL be the frame word, sampled at capture.
REQ-007 det_clr  output  1  SHALL be a one-cycle clear pulse to the downstream detector.
REQ-008 det_valid  output  1  SHALL mean det_bit holds a bit offered to the detector.
REQ-009 det_bit  output  1  SHALL be the current serial bit.
REQ-010 det_ready  input  1  SHALL mean the detector accepts det_bit this cycle.
REQ-011 det_hit  input  1  SHALL be the detector's one-cycle match pulse, 1 cycle after the accepting transfer.
REQ-012 busy  output  1  SHALL be high in every state except IDLE.
REQ-013 done  output  1  SHALL pulse for exactly one cycle when a frame completes.
REQ-014 hit_cnt  output  4  SHALL count det_hit pulses within the current frame.
REQ-015 found  output  1  SHALL be high when hit_cnt is non-zero.
REQ-016 drop  output  1  SHALL be a sticky flag for a start request ignored while busy.
REQ-017 frame_cnt  output  8  SHALL count completed frames.

Function
REQ-018 button SHALL pass through a 2-flop synchronizer; start SHALL be the rising edge of the synchronized signal (third-stage compare), one cycle wide.
REQ-019 FSM states SHALL be IDLE, CLR, SHIFT, DRAIN, DONE.
REQ-020 IDLE + start -> CLR; else stay.
REQ-021 CLR (1 cycle): det_clr=1, switch SHALL be captured into the shift register, bit index SHALL load 0, hit_cnt SHALL clear to 0, drop SHALL clear to 0; -> SHIFT.
REQ-022 SHIFT: det_valid=1; det_bit = captured[WIDTH-1-idx] if MSB_FIRST else captured[idx]; det_bit SHALL be held stable until det_valid & det_ready.
REQ-023 On transfer in SHIFT, idx SHALL increment; on the transfer with idx = WIDTH-1 -> DRAIN.
REQ-024 DRAIN (1 cycle, det_valid=0) SHALL admit the det_hit belonging to the final bit; -> DONE.
REQ-025 DONE (1 cycle): done=1, frame_cnt SHALL increment modulo 256 (255 -> 0); -> IDLE.
REQ-026 hit_cnt SHALL increment on det_hit only in SHIFT or DRAIN, saturating at 15; det_hit in IDLE, CLR or DONE SHALL be ignored.
REQ-027 hit_cnt, found SHALL hold their values in IDLE until the next CLR.
REQ-028 start while busy SHALL NOT restart or alter the frame; it SHALL set drop=1.
REQ-029 Switch changes after CLR SHALL NOT affect transmitted bits.
REQ-030 det_ready held low SHALL stall SHIFT indefinitely with no bit lost or repeated.
REQ-031 Frame latency with det_ready constantly 1: start cycle S, det_clr at S+1, bits at S+2..S+WIDTH+1, done at S+WIDTH+3.
REQ-032 All outputs SHALL be registered or decoded directly from the state register; no combinational path from det_ready to det_valid.

Reset
REQ-033 rst low SHALL immediately force: state IDLE, det_clr=0, det_valid=0, det_bit=0, busy=0, done=0, hit_cnt=0, found=0, drop=0, frame_cnt=0, synchronizer flops=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame with no done pulse and no frame_cnt increment.
REQ-035 A button held high through reset release SHALL NOT produce a start; only a later low-to-high transition does.

Verification
REQ-036 switch=8'b1011_0100, MSB_FIRST=1, det_ready=1, button pulse -> det_bit sequence 1,0,1,1,0,1,0,0; done exactly WIDTH+3 cycles after start; frame_cnt=1.
REQ-037 det_ready toggled pseudo-randomly, switch=8'hA5 -> transferred bits exactly A5 MSB-first, det_bit stable during every stall.
REQ-038 det_hit pulsed on 3 transfers, including the final bit (arriving in DRAIN) -> hit_cnt=3, found=1 after done; det_hit injected in IDLE -> hit_cnt unchanged.
REQ-039 Second button press during SHIFT -> frame unaffected, one done, drop=1; next accepted start clears drop at CLR.
REQ-040 rst low at 4th bit -> all outputs at reset values asynchronously, no done; following frame runs normally with frame_cnt=1.
REQ-041 256 back-to-back frames -> frame_cnt wraps to 0; MSB_FIRST=0, switch=8'h01 -> first det_bit=1.
